// File: rtl/rv32_pipeline_pkg.sv
// -----------------------------------------------------------------------------
// rv32_pipeline_pkg
// Shared types for the RV32 pipeline memory arbiter:
//   mem_arb_state_t : arbiter FSM states (IDLE, ISSUE, WAIT_R, DONE)
//   arb_owner_t     : which requester owns the in-flight transaction
//   mem_req_t       : latched memory request (addr, wdata, wstrb, we)
// -----------------------------------------------------------------------------
package rv32_pipeline_pkg;

    localparam int unsigned MEM_ARB_ADDR_MAX_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_R,
        DONE
    } mem_arb_state_t;

    typedef enum logic [1:0] {
        OWNER_NONE,
        OWNER_IF,
        OWNER_DATA
    } arb_owner_t;

    typedef struct packed {
        logic [MEM_ARB_ADDR_MAX_W-1:0] addr;
        logic [31:0]                   wdata;
        logic [3:0]                    wstrb;
        logic                          we;
    } mem_req_t;

endpackage

// File: rtl/rv32_mem_arbiter_perf.sv
// -----------------------------------------------------------------------------
// mem_arb_perf_counters
// Free-running 32-bit event counters for the memory arbiter. Counters wrap
// silently and clear on reset. Only instantiated when MEM_ARB_PERF_EN is
// defined.
//   clk, rst     : clock, asynchronous active-high reset
//   i_if_done    : fetch completion pulse
//   i_d_done     : data completion pulse
//   i_wait       : one memory wait cycle (no grant / no read data yet)
//   o_if_cnt     : fetch completions
//   o_d_cnt      : data completions
//   o_wait_cnt   : wait cycles
// -----------------------------------------------------------------------------
module mem_arb_perf_counters (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_if_done,
    input  logic        i_d_done,
    input  logic        i_wait,
    output logic [31:0] o_if_cnt,
    output logic [31:0] o_d_cnt,
    output logic [31:0] o_wait_cnt
);

    logic [31:0] r_if_cnt;
    logic [31:0] r_d_cnt;
    logic [31:0] r_wait_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_if_cnt   <= '0;
            r_d_cnt    <= '0;
            r_wait_cnt <= '0;
        end else begin
            if (i_if_done) r_if_cnt   <= r_if_cnt + 32'd1;
            if (i_d_done)  r_d_cnt    <= r_d_cnt + 32'd1;
            if (i_wait)    r_wait_cnt <= r_wait_cnt + 32'd1;
        end
    end

    assign o_if_cnt   = r_if_cnt;
    assign o_d_cnt    = r_d_cnt;
    assign o_wait_cnt = r_wait_cnt;

endmodule

// File: rtl/rv32_mem_arbiter.sv
// -----------------------------------------------------------------------------
// rv32_mem_arbiter
// Shares one single-port memory bus between the IF-stage fetch requester and
// the MEM-stage load/store requester. Data has priority; a pending fetch is
// forced through after FETCH_STARVE_LIMIT consecutive data grants. At most one
// transaction is outstanding.
//   Parameters : FETCH_STARVE_LIMIT (1..15), ADDR_W (<= 32)
//   clk, rst   : clock, asynchronous active-high reset
//   if_*       : fetch request/address in; rdata/ready/stall out
//   d_*        : load/store request, address, wdata, wstrb in;
//                rdata/ready/stall out
//   m_*        : memory bus (req/we/addr/wdata/wstrb out; gnt/rvalid/rdata in)
//   perf_*     : performance counters, live only with MEM_ARB_PERF_EN defined,
//                otherwise tied to zero
// -----------------------------------------------------------------------------
module rv32_mem_arbiter
    import rv32_pipeline_pkg::*;
#(
    parameter int unsigned FETCH_STARVE_LIMIT = 4,
    parameter int unsigned ADDR_W             = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_ready,
    output logic              if_stall,
    input  logic              d_rd,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    input  logic [3:0]        d_wstrb,
    output logic [31:0]       d_rdata,
    output logic              d_ready,
    output logic              d_stall,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [31:0]       m_wdata,
    output logic [3:0]        m_wstrb,
    input  logic              m_gnt,
    input  logic              m_rvalid,
    input  logic [31:0]       m_rdata,
    output logic [31:0]       perf_if_cnt,
    output logic [31:0]       perf_d_cnt,
    output logic [31:0]       perf_wait_cnt
);

    localparam logic [3:0]        STARVE_LIMIT = 4'(FETCH_STARVE_LIMIT);
    localparam logic [ADDR_W-1:0] FETCH_MASK   = ~ADDR_W'(3);

    mem_arb_state_t r_state;
    mem_arb_state_t w_state_nxt;
    arb_owner_t     r_owner;
    mem_req_t       r_req;
    logic [3:0]     r_starve;
    logic [31:0]    r_if_rdata;
    logic [31:0]    r_d_rdata;

    logic w_d_req;
    logic w_grant_if;
    logic w_grant_d;

    // Fetch only wins when data is idle or the fetch has been starved long enough.
    assign w_d_req    = d_rd | d_wr;
    assign w_grant_if = if_req & (~w_d_req | (r_starve == STARVE_LIMIT));
    assign w_grant_d  = w_d_req & ~w_grant_if;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_grant_if | w_grant_d) w_state_nxt = ISSUE;
            ISSUE:   if (m_gnt) w_state_nxt = r_req.we ? DONE : WAIT_R;
            WAIT_R:  if (m_rvalid) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner    <= OWNER_NONE;
            r_req      <= '0;
            r_starve   <= '0;
            r_if_rdata <= '0;
            r_d_rdata  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_if) begin
                        r_owner     <= OWNER_IF;
                        r_req.addr  <= MEM_ARB_ADDR_MAX_W'(if_addr & FETCH_MASK);
                        r_req.wdata <= '0;
                        r_req.wstrb <= '0;
                        r_req.we    <= 1'b0;
                        r_starve    <= '0;
                    end else if (w_grant_d) begin
                        // d_rd together with d_wr is treated as a store.
                        r_owner     <= OWNER_DATA;
                        r_req.addr  <= MEM_ARB_ADDR_MAX_W'(d_addr);
                        r_req.wdata <= d_wdata;
                        r_req.wstrb <= d_wstrb;
                        r_req.we    <= d_wr;
                        if (!if_req)
                            r_starve <= '0;
                        else if (r_starve != STARVE_LIMIT)
                            r_starve <= r_starve + 4'd1;
                    end
                end
                WAIT_R: begin
                    if (m_rvalid) begin
                        if (r_owner == OWNER_IF)   r_if_rdata <= m_rdata;
                        if (r_owner == OWNER_DATA) r_d_rdata  <= m_rdata;
                    end
                end
                DONE:    r_owner <= OWNER_NONE;
                default: ;
            endcase
        end
    end

    assign m_req    = (r_state == ISSUE);
    assign m_we     = m_req & r_req.we;
    assign m_addr   = r_req.addr[ADDR_W-1:0];
    assign m_wdata  = r_req.wdata;
    assign m_wstrb  = r_req.wstrb;

    assign if_ready = (r_state == DONE) && (r_owner == OWNER_IF);
    assign d_ready  = (r_state == DONE) && (r_owner == OWNER_DATA);
    assign if_rdata = r_if_rdata;
    assign d_rdata  = r_d_rdata;
    assign if_stall = if_req & ~if_ready;
    assign d_stall  = w_d_req & ~d_ready;

`ifdef MEM_ARB_PERF_EN
    logic w_wait;

    assign w_wait = ((r_state == ISSUE) & ~m_gnt) | ((r_state == WAIT_R) & ~m_rvalid);

    mem_arb_perf_counters u_perf (
        .clk        (clk),
        .rst        (rst),
        .i_if_done  (if_ready),
        .i_d_done   (d_ready),
        .i_wait     (w_wait),
        .o_if_cnt   (perf_if_cnt),
        .o_d_cnt    (perf_d_cnt),
        .o_wait_cnt (perf_wait_cnt)
    );
`else
    assign perf_if_cnt   = '0;
    assign perf_d_cnt    = '0;
    assign perf_wait_cnt = '0;
`endif

endmodule
